clock_reset_broadcast: RTL and testbench
========================================

Name: clock_reset_broadcast

Overview:
Parametrised clock/reset fan-out node that distributes one input clock to NUM_OUT consumer domains. It generates a per-channel reset for each output with asynchronous assertion and synchronised deassertion. After a global reset, channels are released in a staggered sequence to limit inrush and ordering hazards. In normal operation, software can pulse-reset any single channel without disturbing the others. It sits where a fixed, pass-through clock broadcast node sat before, between the clock source and multiple sub-system clock sinks.

Parameters:
NUM_OUT, 2, number of output clock/reset channels (>=1)
SYNC_STAGES, 2, reset-deassertion synchroniser depth (>=2)
STAGGER, 4, cycles between successive channel releases after global reset (0 = all channels release together)
PULSE_CYCLES, 8, length of a software-requested channel reset pulse, in cycles (>=1)

Ports:
auto_in_clock  input  1  sole clock; all sequential logic is on its rising edge
auto_in_reset_n  input  1  asynchronous, active-low reset
auto_out_clock  output  NUM_OUT  each bit equals auto_in_clock (combinational broadcast, no gating)
auto_out_reset  output  NUM_OUT  per-channel reset, active-high, registered
sw_reset_req  input  NUM_OUT  per-channel software reset request, rising-edge triggered
sw_reset_ack  output  NUM_OUT  one-cycle pulse when a software reset pulse completes
all_released  output  1  high when every channel is out of reset

Behaviour:
- Async reset (auto_in_reset_n=0), effective immediately with no clock edge required:
  - auto_out_reset = all 1s; sw_reset_ack = 0; all_released = 0.
  - Synchroniser chain cleared; FSM = HOLD; all counters = 0; request edge-detect registers = 0.
- Reset synchroniser: a SYNC_STAGES-deep flop chain shifts in 1 after auto_in_reset_n rises. Define edge N as the Nth rising edge after release; the internal sync_ok signal goes high after edge SYNC_STAGES.
- FSM states:
  - HOLD: wait for sync_ok. Move to SEQ at the edge where sync_ok is first seen high.
  - SEQ: channel k's reset deasserts after edge SYNC_STAGES+1+k*STAGGER. A stagger counter of width clog2(STAGGER*NUM_OUT+1) drives this.
    - When the last channel releases, all_released=1 at the same edge and the FSM moves to RUN.
    - STAGGER=0: all channels deassert after edge SYNC_STAGES+1.
  - RUN: software pulse handling is enabled, as described below.
- Software pulse (RUN only):
  - A 0->1 transition of sw_reset_req[i] sampled at edge E asserts auto_out_reset[i] after edge E.
  - The reset is held for exactly PULSE_CYCLES cycles, deasserting after edge E+PULSE_CYCLES.
  - sw_reset_ack[i]=1 for exactly the cycle after edge E+PULSE_CYCLES.
  - Each channel has an independent counter of width clog2(PULSE_CYCLES+1). Simultaneous requests on several channels run concurrently and independently.
- Request rules:
  - A request held high produces exactly one pulse. A new pulse requires the request to go low and then high again.
  - Rising edges during an active pulse on the same channel are ignored; the counter is not restarted.
  - Rising edges during HOLD or SEQ are ignored and not remembered. The edge detector still tracks the input level, so a request already high when RUN is entered does not fire.
- all_released is registered and equals the NOR of auto_out_reset. It goes low for the duration of any software pulse.
- Global reset mid-operation: all in-flight pulses and the sequence are aborted with no ack, and the full HOLD/SEQ sequence repeats.
- auto_out_clock never glitches and never stops; only the resets are sequenced.

Test Plan:
All scenarios use NUM_OUT=3, SYNC_STAGES=2, STAGGER=4, PULSE_CYCLES=8 unless noted.
1. Release auto_in_reset_n between edges 0 and 1 -> auto_out_reset[0] falls after edge 3, [1] after edge 7, [2] after edge 11; all_released rises after edge 11.
2. Free-running auto_in_clock -> every auto_out_clock bit matches auto_in_clock at all times, including during reset.
3. In RUN, sw_reset_req[1] rises at sampled edge 20 -> auto_out_reset[1]=1 after edges 20..27, 0 after edge 28. sw_reset_ack[1]=1 only after edge 28. all_released=0 over the same window. Channels 0 and 2 stay 0 throughout.
4. Hold sw_reset_req[0] high for 30 cycles -> exactly one 8-cycle pulse and one ack. Toggle sw_reset_req[2] during SEQ (edge 6) -> no pulse.
5. Drive auto_in_reset_n low mid-pulse (channel 1 at cycle 4 of 8), with no clock edge -> all auto_out_reset=1 immediately and no ack ever fires. After release, test 1's timing repeats exactly.
6. STAGGER=0 build: all three resets fall after edge 3. Then requests on channels 0 and 2 at the same edge -> both pulse for 8 cycles, and both acks fire in the same cycle.

Source files
------------

// File: rtl/clock_reset_broadcast.sv
// rtl/clock_reset_broadcast.sv - clock fan-out with staggered per-channel reset release and software reset pulses
// Resets assert asynchronously, release synchronously in a staggered order, then accept per-channel pulse requests.
module clock_reset_broadcast #(
  parameter int NUM_OUT      = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int STAGGER      = 4,
  parameter int PULSE_CYCLES = 8
) (
  input  logic               auto_in_clock,
  input  logic               auto_in_reset_n,
  output logic [NUM_OUT-1:0] auto_out_clock,
  output logic [NUM_OUT-1:0] auto_out_reset,
  input  logic [NUM_OUT-1:0] sw_reset_req,
  output logic [NUM_OUT-1:0] sw_reset_ack,
  output logic               all_released
);

  localparam int SW = (STAGGER * NUM_OUT > 0) ? $clog2(STAGGER * NUM_OUT + 1) : 1;
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam logic [SW-1:0] LAST_AT   = SW'((NUM_OUT - 1) * STAGGER);
  localparam logic [PW-1:0] PULSE_LEN = PW'(PULSE_CYCLES);

  typedef enum logic [1:0] {HOLD, SEQ, RUN} state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                 sync_ok;
  logic [SW-1:0]        stag_cnt;
  logic [SW-1:0]        stag_next;
  logic [NUM_OUT-1:0]   release_now;
  logic [NUM_OUT-1:0]   start;
  logic [NUM_OUT-1:0]   pulse_end;
  logic [NUM_OUT-1:0]   reset_next;
  logic [NUM_OUT-1:0]   req_q;
  logic [PW-1:0]        pulse_cnt [NUM_OUT];

  assign auto_out_clock = {NUM_OUT{auto_in_clock}};
  assign sync_ok        = sync_ff[SYNC_STAGES-1];
  assign stag_next      = stag_cnt + SW'(1);

  always_ff @(posedge auto_in_clock or negedge auto_in_reset_n) begin
    if (!auto_in_reset_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Channel 0 releases on the HOLD->SEQ edge; stag_cnt counts edges since then.
  always_ff @(posedge auto_in_clock or negedge auto_in_reset_n) begin
    if (!auto_in_reset_n) begin
      state    <= HOLD;
      stag_cnt <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (sync_ok) begin
            stag_cnt <= '0;
            state    <= (LAST_AT == '0) ? RUN : SEQ;
          end
        end
        SEQ: begin
          stag_cnt <= stag_next;
          if (stag_next == LAST_AT) state <= RUN;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    release_now = '0;
    start       = '0;
    pulse_end   = '0;
    reset_next  = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      release_now[k] = ((state == HOLD) && sync_ok && (SW'(k * STAGGER) == '0)) ||
                       ((state == SEQ) && (stag_next == SW'(k * STAGGER)));
      // Edges during an active pulse are dropped: start needs an idle counter.
      start[k]       = (state == RUN) && sw_reset_req[k] && !req_q[k] && (pulse_cnt[k] == '0);
      pulse_end[k]   = (state == RUN) && (pulse_cnt[k] == PW'(1));
      if (state != RUN) begin
        reset_next[k] = auto_out_reset[k] & ~release_now[k];
      end else begin
        reset_next[k] = start[k] | (auto_out_reset[k] & ~pulse_end[k]);
      end
    end
  end

  always_ff @(posedge auto_in_clock or negedge auto_in_reset_n) begin
    if (!auto_in_reset_n) begin
      auto_out_reset <= '1;
      sw_reset_ack   <= '0;
      req_q          <= '0;
      all_released   <= 1'b0;
      for (int k = 0; k < NUM_OUT; k++) pulse_cnt[k] <= '0;
    end else begin
      auto_out_reset <= reset_next;
      sw_reset_ack   <= pulse_end;
      req_q          <= sw_reset_req;
      all_released   <= ~|reset_next;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (start[k]) begin
          pulse_cnt[k] <= PULSE_LEN;
        end else if (pulse_cnt[k] != '0) begin
          pulse_cnt[k] <= pulse_cnt[k] - PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_reset_broadcast.sv
// tb/tb_clock_reset_broadcast.sv - directed self-checking bench for clock_reset_broadcast
// Two instances: staggered release (STAGGER=4) and simultaneous release (STAGGER=0).
module tb_clock_reset_broadcast;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst0_n;
  logic [2:0] req;
  logic [2:0] req0;
  logic [2:0] oclk, orst, ack;
  logic [2:0] oclk0, orst0, ack0;
  logic       allr, allr0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_reset_broadcast #(
    .NUM_OUT(3), .SYNC_STAGES(2), .STAGGER(4), .PULSE_CYCLES(8)
  ) u_dut (
    .auto_in_clock(clk),
    .auto_in_reset_n(rst_n),
    .auto_out_clock(oclk),
    .auto_out_reset(orst),
    .sw_reset_req(req),
    .sw_reset_ack(ack),
    .all_released(allr)
  );

  clock_reset_broadcast #(
    .NUM_OUT(3), .SYNC_STAGES(2), .STAGGER(0), .PULSE_CYCLES(8)
  ) u_dut0 (
    .auto_in_clock(clk),
    .auto_in_reset_n(rst0_n),
    .auto_out_clock(oclk0),
    .auto_out_reset(orst0),
    .sw_reset_req(req0),
    .sw_reset_ack(ack0),
    .all_released(allr0)
  );

  task automatic test_reset;
    rst_n = 1'b1; rst0_n = 1'b1; req = '0; req0 = '0;
    #1;
    rst_n = 1'b0; rst0_n = 1'b0;
    #1;
    checks++;
    if (orst !== 3'b111) begin errors++; $display("FAIL reset_orst got=%b exp=111", orst); end
    checks++;
    if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack got=%b exp=000", ack); end
    checks++;
    if (allr !== 1'b0) begin errors++; $display("FAIL reset_allr got=%b exp=0", allr); end
    checks++;
    if (orst0 !== 3'b111) begin errors++; $display("FAIL reset_orst0 got=%b exp=111", orst0); end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (orst !== 3'b111 || allr !== 1'b0) begin
        errors++; $display("FAIL reset_held orst=%b allr=%b exp=111/0", orst, allr);
      end
    end
  endtask

  task automatic test_clock;
    repeat (8) begin
      #5;
      checks++;
      if (oclk !== {3{clk}} || oclk0 !== {3{clk}}) begin
        errors++; $display("FAIL clock_bcast oclk=%b oclk0=%b clk=%b", oclk, oclk0, clk);
      end
    end
  endtask

  task automatic test_release_sequence;
    logic [2:0] exp;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      @(posedge clk); #1;
      exp = {(n < 11), (n < 7), (n < 3)};
      checks++;
      if (orst !== exp) begin errors++; $display("FAIL seq_orst edge=%0d got=%b exp=%b", n, orst, exp); end
      checks++;
      if (allr !== (n >= 11)) begin errors++; $display("FAIL seq_allr edge=%0d got=%b exp=%b", n, allr, (n >= 11)); end
      checks++;
      if (ack !== 3'b000) begin errors++; $display("FAIL seq_ack edge=%0d got=%b exp=000", n, ack); end
    end
  endtask

  task automatic test_sw_pulse;
    req[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      checks++;
      if (orst !== ((j < 8) ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL pulse_orst j=%0d got=%b exp=%b", j, orst, ((j < 8) ? 3'b010 : 3'b000));
      end
      checks++;
      if (ack !== ((j == 8) ? 3'b010 : 3'b000)) begin
        errors++; $display("FAIL pulse_ack j=%0d got=%b exp=%b", j, ack, ((j == 8) ? 3'b010 : 3'b000));
      end
      checks++;
      if (allr !== (j >= 8)) begin errors++; $display("FAIL pulse_allr j=%0d got=%b exp=%b", j, allr, (j >= 8)); end
    end
    req[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_held_request;
    int hi;
    int acks;
    for (int pass = 0; pass < 2; pass++) begin
      hi = 0; acks = 0;
      req[0] = 1'b1;
      repeat (30) begin
        @(posedge clk); #1;
        if (orst[0]) hi++;
        if (ack[0]) acks++;
      end
      req[0] = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (hi != 8) begin errors++; $display("FAIL held_len pass=%0d got=%0d exp=8", pass, hi); end
      checks++;
      if (acks != 1) begin errors++; $display("FAIL held_acks pass=%0d got=%0d exp=1", pass, acks); end
    end
  endtask

  task automatic test_seq_ignore;
    logic [2:0] exp;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      exp = {(n < 11), (n < 7), (n < 3)};
      checks++;
      if (orst !== exp) begin errors++; $display("FAIL ignore_orst edge=%0d got=%b exp=%b", n, orst, exp); end
      checks++;
      if (ack !== 3'b000) begin errors++; $display("FAIL ignore_ack edge=%0d got=%b exp=000", n, ack); end
      if (n == 5) req[2] = 1'b1;
      if (n == 7) req[2] = 1'b0;
      if (n == 9) req[0] = 1'b1;
    end
    req[0] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_pulse;
    req[1] = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (orst !== 3'b010) begin errors++; $display("FAIL midpulse_active got=%b exp=010", orst); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (orst !== 3'b111) begin errors++; $display("FAIL midpulse_async got=%b exp=111", orst); end
    checks++;
    if (allr !== 1'b0 || ack !== 3'b000) begin
      errors++; $display("FAIL midpulse_flags allr=%b ack=%b exp=0/000", allr, ack);
    end
    req[1] = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 3'b000 || orst !== 3'b111) begin
        errors++; $display("FAIL midpulse_hold ack=%b orst=%b exp=000/111", ack, orst);
      end
    end
    test_release_sequence();
  endtask

  task automatic test_stagger_zero;
    @(posedge clk); #2;
    rst0_n = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      checks++;
      if (orst0 !== ((n < 3) ? 3'b111 : 3'b000)) begin
        errors++; $display("FAIL s0_orst edge=%0d got=%b exp=%b", n, orst0, ((n < 3) ? 3'b111 : 3'b000));
      end
      checks++;
      if (allr0 !== (n >= 3)) begin errors++; $display("FAIL s0_allr edge=%0d got=%b exp=%b", n, allr0, (n >= 3)); end
    end
    req0 = 3'b101;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      checks++;
      if (orst0 !== ((j < 8) ? 3'b101 : 3'b000)) begin
        errors++; $display("FAIL s0_pulse_orst j=%0d got=%b exp=%b", j, orst0, ((j < 8) ? 3'b101 : 3'b000));
      end
      checks++;
      if (ack0 !== ((j == 8) ? 3'b101 : 3'b000)) begin
        errors++; $display("FAIL s0_pulse_ack j=%0d got=%b exp=%b", j, ack0, ((j == 8) ? 3'b101 : 3'b000));
      end
      checks++;
      if (allr0 !== (j >= 8)) begin errors++; $display("FAIL s0_pulse_allr j=%0d got=%b exp=%b", j, allr0, (j >= 8)); end
    end
    req0 = 3'b000;
  endtask

  initial begin
    test_reset();
    test_clock();
    test_release_sequence();
    test_clock();
    test_sw_pulse();
    test_held_request();
    test_seq_ignore();
    test_reset_mid_pulse();
    test_stagger_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
